// File: rtl/draw_ladder_array_pkg.sv
// Shared types for the ladder sprite overlay: ladder geometry, default table, FSM states.
package ladder_pkg;

  localparam int MAX_LADDERS      = 8;
  localparam int DEF_LADDER_WIDTH = 32;

  typedef struct packed {
    logic [10:0] hstart;
    logic [10:0] vstart;
    logic [10:0] vstop;
  } ladder_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REVEAL = 2'd1,
    SHOWN  = 2'd2
  } ladder_state_e;

  // Concatenation order: entry 7 first, entry 0 last.
  localparam ladder_t [MAX_LADDERS-1:0] LADDER_TABLE = {
    ladder_t'{11'd800, 11'd400, 11'd450},
    ladder_t'{11'd700, 11'd10,  11'd60},
    ladder_t'{11'd600, 11'd300, 11'd380},
    ladder_t'{11'd500, 11'd50,  11'd120},
    ladder_t'{11'd400, 11'd150, 11'd250},
    ladder_t'{11'd300, 11'd100, 11'd180},
    ladder_t'{11'd110, 11'd240, 11'd340},
    ladder_t'{11'd100, 11'd200, 11'd300}
  };

endpackage

// File: rtl/draw_ladder_array_if.sv
// VGA timing + colour bundle passed between draw stages.
interface vga_if;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;
  logic [11:0] rgb;

  modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
  modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/delay.sv
// Generic register delay line, CLK_DEL stages, synchronous active-low clear.
module delay #(
  parameter int WIDTH   = 8,
  parameter int CLK_DEL = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [CLK_DEL-1:0][WIDTH-1:0] pipe;

  always_ff @(posedge clk) begin
    if (!rst) begin
      pipe <= '0;
    end else begin
      pipe[0] <= din;
      for (int i = 1; i < CLK_DEL; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign dout = pipe[CLK_DEL-1];

endmodule

// File: rtl/draw_ladder_array_hit_sel.sv
// Per-channel window test against the current pixel; lowest-index hit wins the ROM address.
module ladder_hit_sel
  import ladder_pkg::*;
#(
  parameter int NUM_LADDERS  = 6,
  parameter int LADDER_WIDTH = DEF_LADDER_WIDTH
) (
  input  logic [10:0]                  hcount,
  input  logic [10:0]                  vcount,
  input  ladder_t [NUM_LADDERS-1:0]    ladders,
  input  logic [NUM_LADDERS-1:0]       en,
  input  logic                         reveal,
  input  logic [10:0]                  reveal_h,
  output logic                         hit,
  output logic [9:0]                   addr
);

  logic [NUM_LADDERS-1:0]       lane_hit;
  logic [NUM_LADDERS-1:0][9:0]  lane_addr;

  for (genvar k = 0; k < NUM_LADDERS; k++) begin : g_lane
    logic signed [12:0] grow_top;
    logic signed [12:0] base_top;
    logic signed [12:0] vis_top;
    logic        [11:0] hend;

    // 13-bit signed so vstop - reveal_h + 1 may go negative without wrapping.
    assign grow_top = $signed({2'b00, ladders[k].vstop}) - $signed({2'b00, reveal_h}) + 13'sd1;
    assign base_top = $signed({2'b00, ladders[k].vstart});
    assign vis_top  = (reveal && grow_top > base_top) ? grow_top : base_top;
    assign hend     = {1'b0, ladders[k].hstart} + 12'(LADDER_WIDTH);

    assign lane_hit[k] = en[k]
                      && hcount >= ladders[k].hstart && {1'b0, hcount} < hend
                      && $signed({2'b00, vcount}) >= vis_top
                      && vcount <= ladders[k].vstop;
    assign lane_addr[k] = {5'(vcount - ladders[k].vstart), 5'(hcount - ladders[k].hstart)};
  end

  // Scan high to low so the lowest matching index is the last write.
  always_comb begin
    hit  = 1'b0;
    addr = '0;
    for (int k = NUM_LADDERS-1; k >= 0; k--) begin
      if (lane_hit[k]) begin
        hit  = 1'b1;
        addr = lane_addr[k];
      end
    end
  end

endmodule

// File: rtl/draw_ladder_array.sv
// Ladder sprite overlay: 3-clk pipeline (hit/addr, ROM read, colour mux) plus bottom-up reveal FSM.
module draw_ladder_array
  import ladder_pkg::*;
#(
  parameter int                         NUM_LADDERS  = 6,
  parameter int                         LADDER_WIDTH = ladder_pkg::DEF_LADDER_WIDTH,
  parameter ladder_t [NUM_LADDERS-1:0]  LADDERS      = ladder_pkg::LADDER_TABLE[NUM_LADDERS-1:0],
  parameter logic [NUM_LADDERS-1:0]     ANIM_MASK    = '0,
  parameter int                         REVEAL_STEP  = 8,
  parameter logic [11:0]                BLANK_RGB    = 12'h888
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_game,
  input  logic                   animation,
  input  logic                   reveal_en,
  input  logic [NUM_LADDERS-1:0] ladder_en,
  input  logic [11:0]            rgb_pixel,
  output logic [9:0]             pixel_addr,
  output logic                   reveal_done,
  vga_if.in                      in,
  vga_if.out                     out
);

  function automatic logic [11:0] max_height();
    logic [11:0] m;
    m = '0;
    for (int k = 0; k < NUM_LADDERS; k++)
      if ({1'b0, LADDERS[k].vstop} - {1'b0, LADDERS[k].vstart} + 12'd1 > m)
        m = {1'b0, LADDERS[k].vstop} - {1'b0, LADDERS[k].vstart} + 12'd1;
    return m;
  endfunction

  localparam logic [11:0] MAX_H = max_height();

  ladder_state_e state;
  logic [10:0]   reveal_h;
  logic [11:0]   reveal_sum;
  logic [10:0]   reveal_nxt;
  logic          tick;

  assign tick       = (in.hcount == '0) && (in.vcount == '0);
  assign reveal_sum = {1'b0, reveal_h} + 12'(REVEAL_STEP);
  assign reveal_nxt = (reveal_sum > 12'd1023) ? 11'd1023 : reveal_sum[10:0];

  // reveal_h only moves on the frame tick so a frame is drawn with one height.
  always_ff @(posedge clk) begin
    if (!rst || !start_game) begin
      state       <= IDLE;
      reveal_h    <= '0;
      reveal_done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          reveal_h    <= '0;
          state       <= reveal_en ? REVEAL : SHOWN;
          reveal_done <= !reveal_en;
        end
        REVEAL: if (tick) begin
          reveal_h <= reveal_nxt;
          if ({1'b0, reveal_nxt} >= MAX_H) begin
            state       <= SHOWN;
            reveal_done <= 1'b1;
          end
        end
        SHOWN:   reveal_done <= 1'b1;
        default: state <= IDLE;
      endcase
    end
  end

  // Stage 1: priority hit and ROM address.
  logic [NUM_LADDERS-1:0] ch_en;
  logic                   sel_hit;
  logic [9:0]             sel_addr;
  logic [1:0]             hit_pipe;

  assign ch_en = (state == IDLE) ? '0 : (ladder_en & ~(animation ? ANIM_MASK : '0));

  ladder_hit_sel #(
    .NUM_LADDERS  (NUM_LADDERS),
    .LADDER_WIDTH (LADDER_WIDTH)
  ) u_hit_sel (
    .hcount   (in.hcount),
    .vcount   (in.vcount),
    .ladders  (LADDERS),
    .en       (ch_en),
    .reveal   (state == REVEAL),
    .reveal_h (reveal_h),
    .hit      (sel_hit),
    .addr     (sel_addr)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      pixel_addr <= '0;
      hit_pipe   <= '0;
    end else begin
      if (sel_hit) pixel_addr <= sel_addr;
      hit_pipe <= {hit_pipe[0], sel_hit};
    end
  end

  // Timing and background colour ride two stages, the output register is the third.
  logic [37:0] tim_d;
  logic [10:0] h_d, v_d;
  logic        hs_d, vs_d, hb_d, vb_d;
  logic [11:0] rgb_d;

  delay #(.WIDTH(38), .CLK_DEL(2)) u_tim_delay (
    .clk  (clk),
    .rst  (rst),
    .din  ({in.hcount, in.vcount, in.hsync, in.vsync, in.hblnk, in.vblnk, in.rgb}),
    .dout (tim_d)
  );

  assign {h_d, v_d, hs_d, vs_d, hb_d, vb_d, rgb_d} = tim_d;

  always_ff @(posedge clk) begin
    if (!rst) begin
      out.hcount <= '0;
      out.vcount <= '0;
      out.hsync  <= 1'b0;
      out.vsync  <= 1'b0;
      out.hblnk  <= 1'b0;
      out.vblnk  <= 1'b0;
      out.rgb    <= '0;
    end else begin
      out.hcount <= h_d;
      out.vcount <= v_d;
      out.hsync  <= hs_d;
      out.vsync  <= vs_d;
      out.hblnk  <= hb_d;
      out.vblnk  <= vb_d;
      if (hb_d || vb_d)     out.rgb <= BLANK_RGB;
      else if (hit_pipe[1]) out.rgb <= rgb_pixel;
      else                  out.rgb <= rgb_d;
    end
  end

endmodule

// File: tb/tb_draw_ladder_array.sv
// Directed vectors for draw_ladder_array; expectations queued with a due cycle, checked by a monitor.
module tb_draw_ladder_array;
  import ladder_pkg::*;

  localparam int NL = 6;
  localparam int K_ADDR = 0, K_RGB = 1, K_TIM = 2, K_DONE = 3;

  typedef struct {
    int          due;
    int          kind;
    int          id;
    logic [25:0] val;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst, start_game, animation, reveal_en;
  logic [NL-1:0] ladder_en;
  logic [11:0]   rgb_pixel;
  logic [9:0]    pixel_addr;
  logic          reveal_done;

  vga_if vin();
  vga_if vout();

  draw_ladder_array #(
    .NUM_LADDERS (NL),
    .ANIM_MASK   (6'b000001)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start_game  (start_game),
    .animation   (animation),
    .reveal_en   (reveal_en),
    .ladder_en   (ladder_en),
    .rgb_pixel   (rgb_pixel),
    .pixel_addr  (pixel_addr),
    .reveal_done (reveal_done),
    .in          (vin),
    .out         (vout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous ROM model: data is a tag of the address it was read from.
  always @(posedge clk) rgb_pixel <= {2'b11, pixel_addr};

  exp_t        sb[$];
  int          n_chk = 0, n_fail = 0, vec_id = 0;
  logic [25:0] cur_tim, act;
  logic        nx_rst = 1'b0, nx_start = 1'b0, nx_anim = 1'b0, nx_reveal = 1'b0;
  logic [NL-1:0] nx_en = '1;

  function automatic string kname(input int k);
    case (k)
      K_ADDR:  return "pixel_addr";
      K_RGB:   return "out_rgb";
      K_TIM:   return "out_timing";
      default: return "reveal_done";
    endcase
  endfunction

  task automatic px(input int h, input int v, input logic [11:0] rgb,
                    input logic hb = 1'b0, input logic vb = 1'b0);
    logic [10:0] hh, vv;
    @(posedge clk); #1;
    hh = 11'(h); vv = 11'(v);
    rst = nx_rst; start_game = nx_start; animation = nx_anim;
    reveal_en = nx_reveal; ladder_en = nx_en;
    vin.hcount = hh; vin.vcount = vv; vin.hsync = hh[1]; vin.vsync = vv[1];
    vin.hblnk = hb; vin.vblnk = vb; vin.rgb = rgb;
    cur_tim = {hh, vv, hh[1], vv[1], hb, vb};
    vec_id++;
  endtask

  task automatic exp_push(input int lag, input int kind, input logic [25:0] val);
    sb.push_back('{due: cyc + lag, kind: kind, id: vec_id, val: val});
  endtask

  task automatic hit(input int h, input int v, input logic [9:0] addr);
    px(h, v, 12'h0f0);
    exp_push(1, K_ADDR, 26'(addr));
    exp_push(3, K_RGB,  26'({2'b11, addr}));
    exp_push(3, K_TIM,  cur_tim);
  endtask

  task automatic miss(input int h, input int v, input logic [11:0] rgb, input logic [9:0] hold);
    px(h, v, rgb);
    exp_push(1, K_ADDR, 26'(hold));
    exp_push(3, K_RGB,  26'(rgb));
  endtask

  task automatic idle();
    px(5, 5, 12'h000);
  endtask

  task automatic tick();
    px(0, 0, 12'h000);
  endtask

  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due == cyc) begin
        case (sb[i].kind)
          K_ADDR:  act = 26'(pixel_addr);
          K_RGB:   act = 26'(vout.rgb);
          K_TIM:   act = {vout.hcount, vout.vcount, vout.hsync, vout.vsync, vout.hblnk, vout.vblnk};
          default: act = 26'(reveal_done);
        endcase
        n_chk++;
        if (act !== sb[i].val) begin
          n_fail++;
          $display("FAIL %s vec%0d cyc%0d: got %0h expected %0h",
                   kname(sb[i].kind), sb[i].id, cyc, act, sb[i].val);
        end
        sb.delete(i);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; start_game = 1'b0; animation = 1'b0; reveal_en = 1'b0; ladder_en = '1;
    vin.hcount = '0; vin.vcount = '0; vin.hsync = 1'b0; vin.vsync = 1'b0;
    vin.hblnk = 1'b0; vin.vblnk = 1'b0; vin.rgb = '0;

    // reset state with non-zero inputs applied
    repeat (3) px(0, 0, 12'hfff, 1'b1, 1'b1);
    exp_push(0, K_TIM, '0); exp_push(0, K_RGB, '0);
    exp_push(0, K_ADDR, '0); exp_push(0, K_DONE, '0);

    // straight to SHOWN
    nx_rst = 1'b1; nx_start = 1'b1; nx_reveal = 1'b0;
    idle(); idle(); exp_push(0, K_DONE, 26'd1);

    // basic address/latency
    hit(110, 205, {5'd5, 5'd10});
    hit(111, 205, {5'd5, 5'd11});
    miss(50, 205, 12'h456, {5'd5, 5'd11});

    // overlap priority, then channel 0 disabled
    hit(120, 250, {5'd18, 5'd20});
    nx_en = 6'b111110;
    hit(120, 250, {5'd10, 5'd10});
    nx_en = '1;

    // blanking inside the ladder
    hit(110, 205, {5'd5, 5'd10});
    px(110, 205, 12'h0f0, 1'b1, 1'b0);
    exp_push(1, K_ADDR, 26'({5'd5, 5'd10})); exp_push(3, K_RGB, 26'h888); exp_push(3, K_TIM, cur_tim);
    px(110, 205, 12'h0f0, 1'b0, 1'b1);
    exp_push(1, K_ADDR, 26'({5'd5, 5'd10})); exp_push(3, K_RGB, 26'h888); exp_push(3, K_TIM, cur_tim);
    hit(111, 206, {5'd6, 5'd11});

    // animation hides channel 0 only
    nx_anim = 1'b1;
    miss(110, 205, 12'h3c3, {5'd6, 5'd11});
    hit(120, 250, {5'd10, 5'd10});
    hit(415, 170, {5'd20, 5'd15});
    nx_anim = 1'b0;
    hit(110, 205, {5'd5, 5'd10});

    // reveal: height 101, step 8 -> SHOWN after 13 ticks
    nx_start = 1'b0; idle(); idle(); exp_push(0, K_DONE, '0);
    nx_start = 1'b1; nx_reveal = 1'b1; idle(); idle(); exp_push(0, K_DONE, '0);
    miss(110, 300, 12'h111, {5'd5, 5'd10});
    for (int f = 1; f <= 13; f++) begin
      tick();
      exp_push(1, K_DONE, 26'(f == 13));
      if (f == 1) begin
        miss(110, 292, 12'h222, {5'd5, 5'd10});
        hit(110, 293, {5'd29, 5'd10});
        hit(110, 300, {5'd4, 5'd10});
      end
      if (f == 12) begin
        miss(110, 204, 12'h333, {5'd4, 5'd10});
        hit(110, 205, {5'd5, 5'd10});
      end
      if (f == 13) hit(110, 200, {5'd0, 5'd10});
    end

    // reset during reveal frame 5
    nx_start = 1'b0; idle();
    nx_start = 1'b1; nx_reveal = 1'b1; idle(); idle();
    for (int f = 0; f < 5; f++) begin tick(); idle(); end
    hit(110, 261, {5'd29, 5'd10});
    miss(110, 260, 12'h444, {5'd29, 5'd10});
    idle(); idle(); idle();
    nx_rst = 1'b0;
    px(110, 290, 12'h0f0);
    exp_push(1, K_ADDR, '0); exp_push(1, K_RGB, '0);
    exp_push(1, K_TIM, '0);  exp_push(1, K_DONE, '0);
    idle();
    nx_rst = 1'b1; idle(); idle();
    miss(110, 300, 12'h555, 10'd0);
    tick(); exp_push(1, K_DONE, '0);
    miss(110, 292, 12'h666, 10'd0);
    hit(110, 293, {5'd29, 5'd10});

    repeat (6) idle();
    @(posedge clk); #1;
    if (sb.size() != 0) begin
      n_fail += sb.size();
      $display("FAIL scoreboard_drain: %0d expectations never checked, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
